// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: command opcodes, FSM states,
// byte-lane constants and the alignment rule.
package mem_access_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // Little-endian byte lanes within a word.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  function automatic logic is_load(input logic [2:0] op);
    is_load = (op <= OP_LBU);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed halfword/byte of a read word and extends it to 32 bits
// according to the load opcode.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] half_sx;

  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (lane)
      LANE_B0: byte_sel = word[7:0];
      LANE_B1: byte_sel = word[15:8];
      LANE_B2: byte_sel = word[23:16];
      LANE_B3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  sign_xtend_16 u_sx (
    .din  (half_sel),
    .dout (half_sx)
  );

  always_comb begin
    case (op)
      OP_LH:   result = half_sx;
      OP_LHU:  result = {16'h0000, half_sel};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/sign_xtend_16.sv
// Sign-extends a 16-bit halfword to 32 bits.
module sign_xtend_16 (
  input  logic [15:0] din,
  output logic [31:0] dout
);
  assign dout = {{16{din[15]}}, din};
endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer: one command at a time, sub-word loads are
// extended, sub-word stores are read-modify-write, misaligned accesses fault.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RDATA,
  output logic        ADDR_ERR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic [31:0] ld_result;
  logic [31:0] merged;

  load_ext u_load_ext (
    .word   (MEM_RDATA),
    .lane   (addr_q[1:0]),
    .op     (op_q),
    .result (ld_result)
  );

  // Sub-word store: replace only the addressed lane of the word just read.
  always_comb begin
    merged = MEM_RDATA;
    if (op_q == OP_SH)
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_d    = OP;
          addr_d  = ADDR;
          wdata_d = WDATA[15:0];
          if (misaligned(OP, ADDR[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (OP == OP_SW) begin
            err_d       = 1'b0;
            mem_wdata_d = WDATA;
            state_d     = ST_WR;
          end else begin
            err_d   = 1'b0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          if (is_load(op_q)) begin
            rdata_d = ld_result;
            state_d = ST_FIN;
          end else begin
            mem_wdata_d = merged;
            state_d     = ST_WR;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WR:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Strobes decode straight from state so they fall with the async reset.
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_FIN);
  assign ADDR_ERR  = (state_q == ST_FIN) && err_q;
  assign MEM_RD    = (state_q == ST_RD);
  assign MEM_WR    = (state_q == ST_WR);
  assign MEM_ADDR  = {addr_q[31:2], 2'b00};
  assign MEM_WDATA = mem_wdata_q;
  assign RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: two controllers (latency 1 and 3) driven in lockstep against
// a memory model that returns the word only in the cycle it is due.
module tb_mem_access_ctrl;

  localparam logic [2:0] C_LW = 3'b000, C_LH = 3'b001, C_LHU = 3'b010, C_LB = 3'b011;
  localparam logic [2:0] C_LBU = 3'b100, C_SW = 3'b101, C_SH = 3'b110, C_SB = 3'b111;
  localparam int K_LOAD = 0, K_SW = 1, K_RMW = 2, K_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic [31:0] ADDR = '0, WDATA = '0, mem_word = '0;

  logic        BUSY_a, DONE_a, ADDR_ERR_a, MEM_RD_a, MEM_WR_a;
  logic [31:0] RDATA_a, MEM_ADDR_a, MEM_WDATA_a, MEM_RDATA_a;
  logic        BUSY_b, DONE_b, ADDR_ERR_b, MEM_RD_b, MEM_WR_b;
  logic [31:0] RDATA_b, MEM_ADDR_b, MEM_WDATA_b, MEM_RDATA_b;

  logic        rd_sr_a = 1'b0;
  logic [2:0]  rd_sr_b = 3'b000;

  int n_chk = 0, n_fail = 0;
  int rd_cyc[2], rd_cnt[2], wr_cyc[2], wr_cnt[2], done_cyc[2], done_cnt[2];
  logic        err_r[2];
  logic [31:0] maddr_r[2], wdat_r[2];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_sr_a <= MEM_RD_a;
    rd_sr_b <= {rd_sr_b[1:0], MEM_RD_b};
  end
  assign MEM_RDATA_a = rd_sr_a    ? mem_word : 32'hDEAD_BEEF;
  assign MEM_RDATA_b = rd_sr_b[2] ? mem_word : 32'hDEAD_BEEF;

  mem_access_ctrl #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .START(START), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY_a), .DONE(DONE_a), .RDATA(RDATA_a), .ADDR_ERR(ADDR_ERR_a),
    .MEM_ADDR(MEM_ADDR_a), .MEM_RD(MEM_RD_a), .MEM_WR(MEM_WR_a),
    .MEM_WDATA(MEM_WDATA_a), .MEM_RDATA(MEM_RDATA_a)
  );

  mem_access_ctrl #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .START(START), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY_b), .DONE(DONE_b), .RDATA(RDATA_b), .ADDR_ERR(ADDR_ERR_b),
    .MEM_ADDR(MEM_ADDR_b), .MEM_RD(MEM_RD_b), .MEM_WR(MEM_WR_b),
    .MEM_WDATA(MEM_WDATA_b), .MEM_RDATA(MEM_RDATA_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int i, input int c, input logic rd, input logic wr,
                        input logic done, input logic err, input logic [31:0] maddr,
                        input logic [31:0] wdat);
    if (rd) begin
      rd_cnt[i]++;
      if (rd_cyc[i] == 0) rd_cyc[i] = c;
      maddr_r[i] = maddr;
    end
    if (wr) begin
      wr_cnt[i]++;
      if (wr_cyc[i] == 0) wr_cyc[i] = c;
      maddr_r[i] = maddr;
      wdat_r[i]  = wdat;
    end
    if (done) begin
      done_cnt[i]++;
      done_cyc[i] = c;
      err_r[i]    = err;
    end
  endtask

  // Issue one command and observe cycles 1..12 after the acceptance edge.
  // With poke set, START is re-asserted with a different command while busy.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit poke);
    for (int i = 0; i < 2; i++) begin
      rd_cyc[i] = 0; rd_cnt[i] = 0; wr_cyc[i] = 0; wr_cnt[i] = 0;
      done_cyc[i] = 0; done_cnt[i] = 0; err_r[i] = 1'b0;
      maddr_r[i] = '0; wdat_r[i] = '0;
    end
    @(negedge clk);
    START = 1'b1; OP = op; ADDR = addr; WDATA = wdata;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (poke && c <= 2) begin
        START = 1'b1; OP = C_SW; ADDR = 32'h0000_0800; WDATA = 32'h5A5A_5A5A;
      end else begin
        START = 1'b0; OP = C_LB; ADDR = 32'hFFFF_FFFF; WDATA = 32'hFFFF_FFFF;
      end
      sample(0, c, MEM_RD_a, MEM_WR_a, DONE_a, ADDR_ERR_a, MEM_ADDR_a, MEM_WDATA_a);
      sample(1, c, MEM_RD_b, MEM_WR_b, DONE_b, ADDR_ERR_b, MEM_ADDR_b, MEM_WDATA_b);
    end
  endtask

  task automatic check_shape(input string tag, input int kind, input logic [31:0] exp_addr);
    int lat;
    int e_rd, e_rdc, e_wr, e_wrc, e_done;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      case (kind)
        K_LOAD:  begin e_rd = 1; e_rdc = 1; e_wr = 0;       e_wrc = 0; e_done = lat + 2; end
        K_SW:    begin e_rd = 0; e_rdc = 0; e_wr = 1;       e_wrc = 1; e_done = 2;       end
        K_RMW:   begin e_rd = 1; e_rdc = 1; e_wr = lat + 2; e_wrc = 1; e_done = lat + 3; end
        default: begin e_rd = 0; e_rdc = 0; e_wr = 0;       e_wrc = 0; e_done = 1;       end
      endcase
      chk($sformatf("%s/L%0d/rd_cyc", tag, lat), 32'(rd_cyc[i]), 32'(e_rd));
      chk($sformatf("%s/L%0d/rd_cnt", tag, lat), 32'(rd_cnt[i]), 32'(e_rdc));
      chk($sformatf("%s/L%0d/wr_cyc", tag, lat), 32'(wr_cyc[i]), 32'(e_wr));
      chk($sformatf("%s/L%0d/wr_cnt", tag, lat), 32'(wr_cnt[i]), 32'(e_wrc));
      chk($sformatf("%s/L%0d/done_cyc", tag, lat), 32'(done_cyc[i]), 32'(e_done));
      chk($sformatf("%s/L%0d/done_cnt", tag, lat), 32'(done_cnt[i]), 32'd1);
      chk($sformatf("%s/L%0d/addr_err", tag, lat), 32'(err_r[i]), (kind == K_FAULT) ? 32'd1 : 32'd0);
      if (kind != K_FAULT)
        chk($sformatf("%s/L%0d/mem_addr", tag, lat), maddr_r[i], exp_addr);
    end
  endtask

  task automatic check_rdata(input string tag, input logic [31:0] exp);
    chk({tag, "/L1/rdata"}, RDATA_a, exp);
    chk({tag, "/L3/rdata"}, RDATA_b, exp);
  endtask

  task automatic check_wdata(input string tag, input logic [31:0] exp);
    chk({tag, "/L1/wdata"}, wdat_r[0], exp);
    chk({tag, "/L3/wdata"}, wdat_r[1], exp);
  endtask

  initial begin
    int done_seen;
    repeat (3) @(negedge clk);
    chk("rst/busy", {30'b0, BUSY_a, BUSY_b}, 32'd0);
    chk("rst/strobes", {28'b0, MEM_RD_a, MEM_WR_a, MEM_RD_b, MEM_WR_b}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst/done_err", {28'b0, DONE_a, ADDR_ERR_a, DONE_b, ADDR_ERR_b}, 32'd0);
    chk("rst/rdata", RDATA_a | RDATA_b, 32'd0);
    chk("rst/mem_addr", MEM_ADDR_a | MEM_ADDR_b, 32'd0);
    chk("rst/mem_wdata", MEM_WDATA_a | MEM_WDATA_b, 32'd0);

    mem_word = 32'h8012_3456;
    run_cmd(C_LB, 32'h0000_0103, 32'h0, 1'b0);
    check_shape("lb", K_LOAD, 32'h0000_0100);
    check_rdata("lb", 32'hFFFF_FF80);
    run_cmd(C_LBU, 32'h0000_0103, 32'h0, 1'b0);
    check_shape("lbu", K_LOAD, 32'h0000_0100);
    check_rdata("lbu", 32'h0000_0080);

    mem_word = 32'h8001_7FFF;
    run_cmd(C_LH, 32'h0000_0102, 32'h0, 1'b0);
    check_shape("lh", K_LOAD, 32'h0000_0100);
    check_rdata("lh", 32'hFFFF_8001);
    run_cmd(C_LHU, 32'h0000_0100, 32'h0, 1'b0);
    check_shape("lhu", K_LOAD, 32'h0000_0100);
    check_rdata("lhu", 32'h0000_7FFF);

    mem_word = 32'h1122_3344;
    run_cmd(C_SB, 32'h0000_0201, 32'hAABB_CCDD, 1'b0);
    check_shape("sb", K_RMW, 32'h0000_0200);
    check_wdata("sb", 32'h1122_DD44);
    run_cmd(C_SH, 32'h0000_0202, 32'h1234_BEEF, 1'b0);
    check_shape("sh", K_RMW, 32'h0000_0200);
    check_wdata("sh", 32'hBEEF_3344);
    run_cmd(C_SW, 32'h0000_0200, 32'h1234_5678, 1'b0);
    check_shape("sw", K_SW, 32'h0000_0200);
    check_wdata("sw", 32'h1234_5678);
    check_rdata("sw_hold", 32'h0000_7FFF);

    run_cmd(C_LW, 32'h0000_0102, 32'h0, 1'b0);
    check_shape("lw_mis", K_FAULT, 32'h0);
    check_rdata("lw_mis", 32'h0000_7FFF);
    run_cmd(C_SH, 32'h0000_0203, 32'h0, 1'b0);
    check_shape("sh_mis", K_FAULT, 32'h0);
    check_rdata("sh_mis", 32'h0000_7FFF);

    mem_word = 32'hCAFE_F00D;
    run_cmd(C_LW, 32'h0000_0300, 32'h0, 1'b1);
    check_shape("lw_poke", K_LOAD, 32'h0000_0300);
    check_rdata("lw_poke", 32'hCAFE_F00D);

    // Reset while both controllers sit in WAIT.
    mem_word = 32'h0000_0055;
    @(negedge clk);
    START = 1'b1; OP = C_LW; ADDR = 32'h0000_0400;
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid/busy", {30'b0, BUSY_a, BUSY_b}, 32'd0);
    chk("rst_mid/strobes", {26'b0, MEM_RD_a, MEM_WR_a, DONE_a, MEM_RD_b, MEM_WR_b, DONE_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (DONE_a || DONE_b || BUSY_a || BUSY_b) done_seen++;
    end
    chk("rst_mid/no_done", 32'(done_seen), 32'd0);
    check_rdata("rst_mid", 32'h0);

    mem_word = 32'h0BAD_F00D;
    run_cmd(C_LW, 32'h0000_0304, 32'h0, 1'b0);
    check_shape("lw_after_rst", K_LOAD, 32'h0000_0304);
    check_rdata("lw_after_rst", 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences every load and store of the multicycle CPU against the word-addressed data memory. It handles the LW/LH/LHU/LB/LBU/SW/SH/SB byte-lane selection and the sign or zero extension of sub-word loads. Sub-word stores are done as read-modify-write. Misaligned addresses are flagged without touching memory. The block sits between the main control unit, which issues one command at a time, and the memory port. It reuses `sign_xtend_16` for halfword sign extension.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from the MEM_RD cycle to the cycle in which MEM_RDATA is valid; legal values ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- START  in  1  command request; accepted only while BUSY=0.
- OP  in  3  command encoding:
  - 000 LW, 001 LH, 010 LHU, 011 LB
  - 100 LBU, 101 SW, 110 SH, 111 SB
- ADDR  in  32  byte address.
- WDATA  in  32  store source; SH uses [15:0], SB uses [7:0].
- BUSY  out  1  high from the cycle after acceptance through the DONE cycle.
- DONE  out  1  one-cycle completion pulse.
- RDATA  out  32  extended load result; updated only on a successful load's DONE; held otherwise.
- ADDR_ERR  out  1  high with DONE when the access was misaligned.
- MEM_ADDR  out  32  {ADDR_q[31:2], 2'b00}.
- MEM_RD  out  1  memory read strobe, one cycle per read.
- MEM_WR  out  1  memory write strobe, one cycle per write.
- MEM_WDATA  out  32  write data, valid while MEM_WR=1.
- MEM_RDATA  in  32  memory read data.

## Operation
- Byte lanes: little-endian. ADDR[1:0]=k selects byte bits [8k+7:8k]. ADDR[1] selects the halfword: 0→[15:0], 1→[31:16].
- Acceptance: START=1 in IDLE latches OP, ADDR, WDATA into OP_q, ADDR_q, WDATA_q. Input changes after acceptance have no effect. START while BUSY=1 is ignored, not queued.
- Alignment check at acceptance:
  - LW/SW: fault if ADDR[1:0]≠0.
  - LH/LHU/SH: fault if ADDR[0]≠0.
  - Byte ops never fault.
  - On fault: go directly to FIN with ADDR_ERR=1; no MEM_RD or MEM_WR; RDATA unchanged.
- States:
  - IDLE
  - RD: MEM_RD=1; load the latency counter.
  - WAIT: MEM_LATENCY cycles; MEM_RDATA is sampled at the end of the last one.
  - WR: MEM_WR=1.
  - FIN: DONE=1.
- Transitions:
  - IDLE→RD for loads, SH, SB.
  - IDLE→WR for SW.
  - IDLE→FIN on fault.
  - RD→WAIT.
  - WAIT→FIN for loads; WAIT→WR for SH/SB.
  - WR→FIN.
  - FIN→IDLE.
- Load results:
  - LW: the word.
  - LH: lane half, sign-extended via `sign_xtend_16`.
  - LHU: lane half, zero-extended.
  - LB/LBU: lane byte, sign- or zero-extended.
- Store data:
  - SW: MEM_WDATA=WDATA_q.
  - SH/SB: the sampled read word with only the addressed lane replaced by WDATA_q[15:0] or WDATA_q[7:0].
- MEM_ADDR is held constant for the whole command. It is don't-care in IDLE and driven 0 after reset.

## Timing
Cycle 0 is the acceptance edge. L = MEM_LATENCY.
- Load: MEM_RD in cycle 1; DONE with RDATA valid in cycle L+2.
- SW: MEM_WR in cycle 1; DONE in cycle 2.
- SH/SB: MEM_RD in cycle 1; MEM_WR in cycle L+2; DONE in cycle L+3.
- Fault: DONE and ADDR_ERR in cycle 1.
- BUSY=0 only in IDLE. The earliest next acceptance is the edge ending the DONE cycle+1, i.e. the first IDLE cycle.
- Reset values: state IDLE; BUSY, DONE, ADDR_ERR, MEM_RD, MEM_WR = 0; RDATA, MEM_ADDR, MEM_WDATA = 0.
- Reset mid-operation: all strobes drop asynchronously with reset_n. The command is discarded and no DONE is produced.
- Latency counter width is $clog2(L+1). The counter never wraps.

## Structure
- Shared package `mem_access_pkg`:
  - OP encodings (OP_LW…OP_SB).
  - State encodings.
  - Lane-select helper constants.
- One sub-module, `load_ext`: combinational lane select plus extension. It takes word, ADDR[1:0] and OP and produces the 32-bit result, instantiating `sign_xtend_16`.
- The store merge stays inline in `mem_access_ctrl`.

## Test plan
- LB ADDR=0x103, memory word 0x80123456 → RDATA=0xFFFFFF80. LBU at the same address → 0x00000080. One MEM_RD; DONE at cycle L+2.
- LH ADDR=0x102, word 0x80017FFF → 0xFFFF8001. LHU ADDR=0x100 → 0x00007FFF. MEM_ADDR=0x100 in both.
- SB ADDR=0x201, WDATA=0xAABBCCDD, word 0x11223344 → MEM_WDATA=0x1122DD44, MEM_WR in cycle L+2, DONE in cycle L+3. SW at 0x200 → MEM_WR in cycle 1, no MEM_RD.
- LW ADDR=0x102 and SH ADDR=0x203 → DONE+ADDR_ERR in cycle 1, no strobes, RDATA keeps its prior value.
- START pulsed during BUSY → ignored. reset_n low during WAIT → strobes and BUSY drop immediately, no DONE. Next LW completes normally.
- MEM_LATENCY=3 build: LW → MEM_RD in cycle 1, DONE in cycle 5. SB → MEM_WR in cycle 5, DONE in cycle 6.
